vga_scan_ctrl: RTL
==================

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 SHALL provide parameter H_DISP, default 640, meaning active pixels per line.
REQ-002 SHALL provide parameters H_FRONT/H_SYNC/H_BACK, defaults 16/96/48, meaning horizontal porch and sync lengths in clocks.
REQ-003 SHALL provide parameters V_DISP/V_FRONT/V_SYNC/V_BACK, defaults 480/10/2/33, meaning vertical timing in lines.
REQ-004 SHALL provide parameter NUM_LAYERS, default 4, meaning number of sprite layers composited.
REQ-005 SHALL provide parameter RESP_LATENCY, default 1, meaning clocks from request address to layer response.
REQ-006 SHALL have port clk_vga, input, 1, pixel clock.
REQ-007 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-008 SHALL have port en_i, input, 1, scan enable.
REQ-009 SHALL have ports req_x_addr_o and req_y_addr_o, output, `H_DISP_LEN and `V_DISP_LEN bits, pixel request coordinates to all sprites.
REQ-010 SHALL have port v_sync_o, output, 1, active-low vertical sync; it also clears sprite address counters.
REQ-011 SHALL have port h_sync_o, output, 1, active-low horizontal sync.
REQ-012 SHALL have ports layer_rgb_i, input, NUM_LAYERS*`COLOR_RGB_DEPTH bits, and layer_alpha_i, input, NUM_LAYERS bits; layer k occupies slice k.
REQ-013 SHALL have port bg_rgb_i, input, `COLOR_RGB_DEPTH bits, background colour.
REQ-014 SHALL have ports vga_rgb_o, output, `COLOR_RGB_DEPTH bits, and de_o, output, 1, data enable.
REQ-015 SHALL have ports frame_start_o, output, 1, one-clock pulse per frame, and collision_o, output, 1, overlap flag.

Function
REQ-016 SHALL count h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of the four H parameters), wrapping to 0 and incrementing v_cnt, which wraps at V_TOTAL-1 to 0.
REQ-017 SHALL drive req_x_addr_o=h_cnt and req_y_addr_o=v_cnt when h_cnt<H_DISP and v_cnt<V_DISP, and all-ones on both otherwise, so no sprite matches during blanking.
REQ-018 SHALL assert h_sync low for h_cnt in [H_DISP+H_FRONT, H_DISP+H_FRONT+H_SYNC) and v_sync low for v_cnt in [V_DISP+V_FRONT, V_DISP+V_FRONT+V_SYNC).
REQ-019 SHALL delay h_sync, v_sync and active flag by RESP_LATENCY+1 clocks into h_sync_o, v_sync_o, de_o, aligned with vga_rgb_o.
REQ-020 SHALL register vga_rgb_o as: lowest-index layer with alpha=1 wins; no alpha set -> bg_rgb_i; de low -> 0.
REQ-021 SHALL pulse frame_start_o for one clock when h_cnt=0 and v_cnt=0 (request side, undelayed).
REQ-022 SHALL, with en_i low, hold h_cnt=v_cnt=0, req addresses all-ones, h_sync_o=v_sync_o=1, de_o=0, vga_rgb_o=0, frame_start_o=0; on re-enable restart at (0,0) with frame_start_o pulse.

Reset
REQ-023 SHALL on rst set h_cnt=v_cnt=0, delay pipelines to idle, h_sync_o=1, v_sync_o=1, de_o=0, vga_rgb_o=0, frame_start_o=0, collision_o=0, req addresses all-ones; reset mid-frame aborts the frame immediately.

Configuration
REQ-024 SHALL, when macro VGA_COLLISION_DETECT_EN is defined, set a sticky flag whenever two or more layer_alpha_i bits are 1 on an active pixel, copy it to collision_o at frame_start, then clear it.
REQ-025 SHALL, when VGA_COLLISION_DETECT_EN is undefined, tie collision_o to 0, keeping the port.

Structure
REQ-026 SHALL take `H_DISP_LEN, `V_DISP_LEN, `COLOR_RGB_DEPTH and default timing constants from the shared define.v header package.
REQ-027 SHALL place the priority mux and collision logic in sub-module vga_layer_mux.

Verification
REQ-028 SHALL check reset: h_sync_o=1, v_sync_o=1, de_o=0, vga_rgb_o=0, req_x_addr_o=1023, req_y_addr_o=511.
REQ-029 SHALL check one line (800 clocks): req_x 0..639 then 1023; h_sync_o low exactly 96 clocks, starting 658 clocks after line start.
REQ-030 SHALL check frame: frame_start_o pulses 420000 clocks apart; v_sync_o low 1600 clocks per frame.
REQ-031 SHALL check priority: layer1 alpha=1 rgb=12'h0F0 and layer2 alpha=1 rgb=12'hFFF -> vga_rgb_o=12'h0F0 two clocks later; no alpha -> bg_rgb_i.
REQ-032 SHALL check collision (macro on): alpha on layers 0 and 3 at (100,50) -> collision_o=1 after next frame_start, 0 after following clean frame; macro off -> always 0.
REQ-033 SHALL check en_i dropped at h_cnt=300: next clock req addresses all-ones; re-enable -> frame_start_o pulse, req (0,0).

Source files
------------

// File: rtl/vga_scan_ctrl_pkg.sv
// Shared VGA definitions: coordinate/colour widths, default timing, scan control bundle.
`ifndef VGA_SCAN_CTRL_DEFINES
`define VGA_SCAN_CTRL_DEFINES
`define H_DISP_LEN 10
`define V_DISP_LEN 9
`define COLOR_RGB_DEPTH 12
`endif

package vga_scan_ctrl_pkg;

  localparam int H_DISP_DEF       = 640;
  localparam int H_FRONT_DEF      = 16;
  localparam int H_SYNC_DEF       = 96;
  localparam int H_BACK_DEF       = 48;
  localparam int V_DISP_DEF       = 480;
  localparam int V_FRONT_DEF      = 10;
  localparam int V_SYNC_DEF       = 2;
  localparam int V_BACK_DEF       = 33;
  localparam int NUM_LAYERS_DEF   = 4;
  localparam int RESP_LATENCY_DEF = 1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } scan_ctl_t;

  localparam scan_ctl_t SCAN_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

endpackage

// File: rtl/vga_layer_mux.sv
// Registered priority mux over sprite layers (lowest index wins) plus optional
// per-frame layer-overlap flag, enabled by VGA_COLLISION_DETECT_EN.
module vga_layer_mux
  import vga_scan_ctrl_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF
) (
  input  logic                                   clk_vga,
  input  logic                                   rst,
  input  logic                                   clear_i,
  input  logic                                   act_i,
  input  logic                                   frame_start_i,
  input  logic [NUM_LAYERS*`COLOR_RGB_DEPTH-1:0] layer_rgb_i,
  input  logic [NUM_LAYERS-1:0]                  layer_alpha_i,
  input  logic [`COLOR_RGB_DEPTH-1:0]            bg_rgb_i,
  output logic [`COLOR_RGB_DEPTH-1:0]            rgb_o,
  output logic                                   collision_o
);

  localparam int D = `COLOR_RGB_DEPTH;

  logic [D-1:0] pix;
  logic [D-1:0] rgb_d, rgb_q;

  always_comb begin
    pix = bg_rgb_i;
    // Walk from the top layer down so the lowest set index is written last.
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (layer_alpha_i[k]) pix = layer_rgb_i[k*D +: D];
    end
    rgb_d = (act_i && !clear_i) ? pix : '0;
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) rgb_q <= '0;
    else     rgb_q <= rgb_d;
  end

  assign rgb_o = rgb_q;

`ifdef VGA_COLLISION_DETECT_EN
  logic hit;
  logic sticky_d, sticky_q;
  logic collision_d, collision_q;

  always_comb begin
    hit = act_i && !clear_i &&
          ((layer_alpha_i & (layer_alpha_i - NUM_LAYERS'(1))) != '0);
    sticky_d    = sticky_q | hit;
    collision_d = collision_q;
    if (frame_start_i) begin
      collision_d = sticky_q;
      sticky_d    = hit;
    end
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      sticky_q    <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      sticky_q    <= sticky_d;
      collision_q <= collision_d;
    end
  end

  assign collision_o = collision_q;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start_i;
  assign collision_o        = 1'b0;
`endif

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster scan: counters, sprite request addresses, sync/DE delayed RESP_LATENCY+1
// to align with the registered layer mux. Collision flag via VGA_COLLISION_DETECT_EN.
module vga_scan_ctrl
  import vga_scan_ctrl_pkg::*;
#(
  parameter int H_DISP       = H_DISP_DEF,
  parameter int H_FRONT      = H_FRONT_DEF,
  parameter int H_SYNC       = H_SYNC_DEF,
  parameter int H_BACK       = H_BACK_DEF,
  parameter int V_DISP       = V_DISP_DEF,
  parameter int V_FRONT      = V_FRONT_DEF,
  parameter int V_SYNC       = V_SYNC_DEF,
  parameter int V_BACK       = V_BACK_DEF,
  parameter int NUM_LAYERS   = NUM_LAYERS_DEF,
  parameter int RESP_LATENCY = RESP_LATENCY_DEF
) (
  input  logic                                   clk_vga,
  input  logic                                   rst,
  input  logic                                   en_i,
  output logic [`H_DISP_LEN-1:0]                 req_x_addr_o,
  output logic [`V_DISP_LEN-1:0]                 req_y_addr_o,
  output logic                                   v_sync_o,
  output logic                                   h_sync_o,
  input  logic [NUM_LAYERS*`COLOR_RGB_DEPTH-1:0] layer_rgb_i,
  input  logic [NUM_LAYERS-1:0]                  layer_alpha_i,
  input  logic [`COLOR_RGB_DEPTH-1:0]            bg_rgb_i,
  output logic [`COLOR_RGB_DEPTH-1:0]            vga_rgb_o,
  output logic                                   de_o,
  output logic                                   frame_start_o,
  output logic                                   collision_o
);

  localparam int H_TOTAL  = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISP + V_FRONT + V_SYNC + V_BACK;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int PIPE     = RESP_LATENCY + 1;
  localparam int HS_START = H_DISP + H_FRONT;
  localparam int VS_START = V_DISP + V_FRONT;

  logic [HW-1:0] h_cnt_d, h_cnt_q;
  logic [VW-1:0] v_cnt_d, v_cnt_q;
  logic          run, active, frame_start, resp_act;
  scan_ctl_t     cur_ctl;
  scan_ctl_t     pipe_d [1:PIPE];
  scan_ctl_t     pipe_q [1:PIPE];

  // Gating with rst keeps the request side idle while reset is held.
  assign run         = en_i && !rst;
  assign active      = run && (int'(h_cnt_q) < H_DISP) && (int'(v_cnt_q) < V_DISP);
  assign frame_start = run && (h_cnt_q == '0) && (v_cnt_q == '0);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!en_i) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (int'(h_cnt_q) == H_TOTAL - 1) begin
      h_cnt_d = '0;
      v_cnt_d = (int'(v_cnt_q) == V_TOTAL - 1) ? '0 : v_cnt_q + VW'(1);
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
    end
  end

  always_comb begin
    cur_ctl = SCAN_IDLE;
    if (run) begin
      cur_ctl.hs  = !((int'(h_cnt_q) >= HS_START) && (int'(h_cnt_q) < HS_START + H_SYNC));
      cur_ctl.vs  = !((int'(v_cnt_q) >= VS_START) && (int'(v_cnt_q) < VS_START + V_SYNC));
      cur_ctl.act = active;
    end
    for (int i = 1; i <= PIPE; i++) pipe_d[i] = SCAN_IDLE;
    if (en_i) begin
      pipe_d[1] = cur_ctl;
      for (int i = 2; i <= PIPE; i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      for (int i = 1; i <= PIPE; i++) pipe_q[i] <= SCAN_IDLE;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      for (int i = 1; i <= PIPE; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  // Active flag as seen when the layer response for that pixel arrives.
  generate
    if (RESP_LATENCY == 0) begin : g_resp_now
      assign resp_act = cur_ctl.act;
    end else begin : g_resp_dly
      assign resp_act = pipe_q[RESP_LATENCY].act;
    end
  endgenerate

  assign req_x_addr_o  = active ? `H_DISP_LEN'(h_cnt_q) : '1;
  assign req_y_addr_o  = active ? `V_DISP_LEN'(v_cnt_q) : '1;
  assign frame_start_o = frame_start;
  assign h_sync_o      = pipe_q[PIPE].hs;
  assign v_sync_o      = pipe_q[PIPE].vs;
  assign de_o          = pipe_q[PIPE].act;

  vga_layer_mux #(
    .NUM_LAYERS (NUM_LAYERS)
  ) u_layer_mux (
    .clk_vga       (clk_vga),
    .rst           (rst),
    .clear_i       (!en_i),
    .act_i         (resp_act),
    .frame_start_i (frame_start),
    .layer_rgb_i   (layer_rgb_i),
    .layer_alpha_i (layer_alpha_i),
    .bg_rgb_i      (bg_rgb_i),
    .rgb_o         (vga_rgb_o),
    .collision_o   (collision_o)
  );

endmodule
